base_sram_arbiter: RTL and testbench

//   Shares the single BaseRAM SRAM between the CPU instruction-fetch port and the data load/store port.

---
 rtl/base_sram_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_base_sram_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/base_sram_arbiter.sv
// Two-port arbiter for the shared BaseRAM SRAM: instruction fetch and data load/store.
// Sequences read/write strobes, returns one-cycle ready pulses and a combinational stall.
module base_sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              inst_req_i,
    input  logic [31:0]       inst_addr_i,
    output logic [31:0]       inst_rdata_o,
    output logic              inst_ready_o,

    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [31:0]       data_addr_i,
    input  logic [31:0]       data_wdata_i,
    input  logic [3:0]        data_sel_i,
    output logic [31:0]       data_rdata_o,
    output logic              data_ready_o,

    output logic              stall_o,

    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic [31:0]       sram_dq_i,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe_o,
    output logic [3:0]        sram_be_n_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWrSetup,
        StWrPulse,
        StWrHold
    } state_e;

    typedef enum logic {
        OwnInst,
        OwnData
    } owner_e;

    localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    logic [3:0]        cnt_q, cnt_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       dq_q, dq_d;
    logic              dq_oe_q, dq_oe_d;
    logic [3:0]        be_n_q, be_n_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic [31:0]       inst_rdata_q, inst_rdata_d;
    logic [31:0]       data_rdata_q, data_rdata_d;
    logic              inst_ready_q, inst_ready_d;
    logic              data_ready_q, data_ready_d;

    logic              inst_elig;
    logic              data_elig;
    logic              grant_inst;
    logic              grant_data;

    // Byte-offset and upper address bits are intentionally not decoded.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr_i, data_addr_i};

    // A port whose ready pulse is showing is masked so its finished request is not re-granted.
    assign inst_elig  = inst_req_i & ~inst_ready_q;
    assign data_elig  = data_req_i & ~data_ready_q;
    assign grant_data = data_elig & (~inst_elig | (last_q == OwnInst));
    assign grant_inst = inst_elig & ~grant_data;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        dq_d         = dq_q;
        dq_oe_d      = dq_oe_q;
        be_n_d       = be_n_q;
        ce_n_d       = ce_n_q;
        oe_n_d       = oe_n_q;
        we_n_d       = we_n_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ready_d = 1'b0;
        data_ready_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_data) begin
                    owner_d = OwnData;
                    last_d  = OwnData;
                    addr_d  = data_addr_i[ADDR_W+1:2];
                    if (!data_we_i) begin
                        state_d = StRd;
                        cnt_d   = CntLoad;
                        ce_n_d  = 1'b0;
                        oe_n_d  = 1'b0;
                        be_n_d  = 4'h0;
                    end else if (data_sel_i != 4'h0) begin
                        state_d = StWrSetup;
                        dq_d    = data_wdata_i;
                        dq_oe_d = 1'b1;
                        be_n_d  = ~data_sel_i;
                        ce_n_d  = 1'b0;
                        we_n_d  = 1'b1;
                    end else begin
                        // Empty byte mask: no strobes, just pass through HOLD to acknowledge.
                        state_d = StWrHold;
                    end
                end else if (grant_inst) begin
                    owner_d = OwnInst;
                    last_d  = OwnInst;
                    addr_d  = inst_addr_i[ADDR_W+1:2];
                    state_d = StRd;
                    cnt_d   = CntLoad;
                    ce_n_d  = 1'b0;
                    oe_n_d  = 1'b0;
                    be_n_d  = 4'h0;
                end
            end

            StRd: begin
                if (cnt_q == 4'h0) begin
                    state_d = StIdle;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    be_n_d  = 4'hF;
                    if (owner_q == OwnInst) begin
                        inst_rdata_d = sram_dq_i;
                        inst_ready_d = 1'b1;
                    end else begin
                        data_rdata_d = sram_dq_i;
                        data_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'h1;
                end
            end

            StWrSetup: begin
                state_d = StWrPulse;
                cnt_d   = CntLoad;
                we_n_d  = 1'b0;
            end

            StWrPulse: begin
                if (cnt_q == 4'h0) begin
                    state_d = StWrHold;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'h1;
                end
            end

            StWrHold: begin
                state_d      = StIdle;
                ce_n_d       = 1'b1;
                we_n_d       = 1'b1;
                dq_oe_d      = 1'b0;
                be_n_d       = 4'hF;
                data_ready_d = 1'b1;
            end

            default: begin
                state_d = StIdle;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                be_n_d  = 4'hF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= OwnInst;
            last_q       <= OwnInst;
            cnt_q        <= 4'h0;
            addr_q       <= '0;
            dq_q         <= 32'h0;
            dq_oe_q      <= 1'b0;
            be_n_q       <= 4'hF;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            dq_q         <= dq_d;
            dq_oe_q      <= dq_oe_d;
            be_n_q       <= be_n_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ready_q <= inst_ready_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign inst_rdata_o = inst_rdata_q;
    assign inst_ready_o = inst_ready_q;
    assign data_rdata_o = data_rdata_q;
    assign data_ready_o = data_ready_q;
    assign sram_addr_o  = addr_q;
    assign sram_dq_o    = dq_q;
    assign sram_dq_oe_o = dq_oe_q;
    assign sram_be_n_o  = be_n_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_we_n_o  = we_n_q;

    assign stall_o = (inst_req_i & ~inst_ready_q) | (data_req_i & ~data_ready_q);

endmodule

// File: tb/tb_base_sram_arbiter.sv
// Scoreboard bench for base_sram_arbiter: directed requests push expected completions,
// an independent monitor pops and compares on every ready pulse.
module tb_base_sram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_sel;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        stall;
    logic [19:0] sram_addr;
    logic [31:0] sram_dq_i;
    logic [31:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [3:0]  sram_be_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    logic        dq_fixed_en;
    logic [31:0] dq_fixed;

    // SRAM read data: a fixed word, or a pattern derived from the word address.
    assign sram_dq_i = dq_fixed_en ? dq_fixed : {12'hABC, sram_addr};

    base_sram_arbiter #(
        .WAIT_CYCLES(2),
        .ADDR_W     (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_req_i  (inst_req),
        .inst_addr_i (inst_addr),
        .inst_rdata_o(inst_rdata),
        .inst_ready_o(inst_ready),
        .data_req_i  (data_req),
        .data_we_i   (data_we),
        .data_addr_i (data_addr),
        .data_wdata_i(data_wdata),
        .data_sel_i  (data_sel),
        .data_rdata_o(data_rdata),
        .data_ready_o(data_ready),
        .stall_o     (stall),
        .sram_addr_o (sram_addr),
        .sram_dq_i   (sram_dq_i),
        .sram_dq_o   (sram_dq_o),
        .sram_dq_oe_o(sram_dq_oe),
        .sram_be_n_o (sram_be_n),
        .sram_ce_n_o (sram_ce_n),
        .sram_oe_n_o (sram_oe_n),
        .sram_we_n_o (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting for ready (t=%0t)", name, $time);
    endtask

    // Scoreboard: port 1 = data, 0 = inst; rdata compared only when chk_rd is set.
    typedef struct packed {
        logic        port;
        logic        chk_rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (!sram_oe_n && !sram_we_n) begin
                failures++;
                $display("FAIL oe_we_overlap actual=both_low required=not_both_low");
            end
            if (inst_ready && data_ready) begin
                checks++;
                failures++;
                $display("FAIL dual_ready actual=both_high required=one_port");
            end else if (inst_ready || data_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready actual=inst%0b_data%0b required=none",
                             inst_ready, data_ready);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("sb_port", {31'h0, data_ready}, {31'h0, mon_e.port});
                    if (mon_e.chk_rd)
                        chk("sb_rdata", data_ready ? data_rdata : inst_rdata, mon_e.rdata);
                end
            end
        end
    end

    // Per-cycle pin trace of the last recorded request, indexed by cycles since req rose.
    logic        tr_ce   [128];
    logic        tr_oe   [128];
    logic        tr_we   [128];
    logic        tr_dqoe [128];
    logic [3:0]  tr_ben  [128];
    logic [19:0] tr_addr [128];
    logic [31:0] tr_dq   [128];

    task automatic push_exp(input logic port, input logic chk_rd, input logic [31:0] rdata);
        exp_t e;
        e.port   = port;
        e.chk_rd = chk_rd;
        e.rdata  = rdata;
        sb_q.push_back(e);
    endtask

    task automatic do_req(input bit is_data, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel, input bit rec,
                          input string name, output int lat);
        bit done;
        done = 1'b0;
        lat  = -1;
        @(posedge clk);
        #1;
        if (is_data) begin
            data_req   = 1'b1;
            data_we    = we;
            data_addr  = addr;
            data_wdata = wdata;
            data_sel   = sel;
        end else begin
            inst_req  = 1'b1;
            inst_addr = addr;
        end
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (rec) begin
                tr_ce[k]   = sram_ce_n;
                tr_oe[k]   = sram_oe_n;
                tr_we[k]   = sram_we_n;
                tr_dqoe[k] = sram_dq_oe;
                tr_ben[k]  = sram_be_n;
                tr_addr[k] = sram_addr;
                tr_dq[k]   = sram_dq_o;
            end
            if (is_data ? data_ready : inst_ready) begin
                lat  = k;
                done = 1'b1;
            end
        end
        #1;
        if (is_data) data_req = 1'b0;
        else inst_req = 1'b0;
        if (!done) timeout_fail(name);
    endtask

    task automatic count_lows(input int last, output int ce_l, output int oe_l,
                              output int we_l);
        ce_l = 0;
        oe_l = 0;
        we_l = 0;
        for (int k = 0; k <= last && k < 128; k++) begin
            if (!tr_ce[k]) ce_l++;
            if (!tr_oe[k]) oe_l++;
            if (!tr_we[k]) we_l++;
        end
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        inst_req = 1'b0;
        data_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] alt_addr [3];
    int          lat, lat_i, lat_d;
    int          ce_l, oe_l, we_l;

    initial begin
        rst_n       = 1'b0;
        inst_req    = 1'b0;
        inst_addr   = 32'h0;
        data_req    = 1'b0;
        data_we     = 1'b0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        data_sel    = 4'h0;
        dq_fixed_en = 1'b0;
        dq_fixed    = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ce_n", {31'h0, sram_ce_n}, 32'h1);
        chk("rst_oe_n", {31'h0, sram_oe_n}, 32'h1);
        chk("rst_we_n", {31'h0, sram_we_n}, 32'h1);
        chk("rst_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
        chk("rst_be_n", {28'h0, sram_be_n}, 32'hF);
        chk("rst_addr", {12'h0, sram_addr}, 32'h0);
        chk("rst_dq_o", sram_dq_o, 32'h0);
        chk("rst_inst_rdata", inst_rdata, 32'h0);
        chk("rst_data_rdata", data_rdata, 32'h0);
        chk("rst_inst_ready", {31'h0, inst_ready}, 32'h0);
        chk("rst_data_ready", {31'h0, data_ready}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        rst_n = 1'b1;

        // Single fetch
        dq_fixed_en = 1'b1;
        dq_fixed    = 32'h2408_0001;
        push_exp(1'b0, 1'b1, 32'h2408_0001);
        do_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, "fetch", lat);
        chk("fetch_latency", lat, 32'd3);
        chk("fetch_addr", {12'h0, tr_addr[1]}, 32'h4);
        chk("fetch_ce_n", {31'h0, tr_ce[1]}, 32'h0);
        chk("fetch_oe_k1", {31'h0, tr_oe[1]}, 32'h0);
        chk("fetch_oe_k2", {31'h0, tr_oe[2]}, 32'h0);
        chk("fetch_oe_k3", {31'h0, tr_oe[3]}, 32'h1);
        count_lows(lat, ce_l, oe_l, we_l);
        chk("fetch_oe_lows", oe_l, 32'd2);
        chk("fetch_we_lows", we_l, 32'd0);
        @(negedge clk);
        chk("fetch_ready_pulse", {31'h0, inst_ready}, 32'h0);
        dq_fixed_en = 1'b0;

        // Partial-word write
        push_exp(1'b1, 1'b0, 32'h0);
        do_req(1'b1, 1'b1, 32'h8000_0104, 32'hDEAD_BEEF, 4'b0011, 1'b1, "write", lat);
        chk("wr_latency", lat, 32'd5);
        chk("wr_addr", {12'h0, tr_addr[1]}, 32'h41);
        chk("wr_be_n_setup", {28'h0, tr_ben[1]}, 32'hC);
        chk("wr_dq_setup", tr_dq[1], 32'hDEAD_BEEF);
        chk("wr_dqoe_setup", {31'h0, tr_dqoe[1]}, 32'h1);
        chk("wr_ce_setup", {31'h0, tr_ce[1]}, 32'h0);
        chk("wr_we_setup", {31'h0, tr_we[1]}, 32'h1);
        chk("wr_we_pulse1", {31'h0, tr_we[2]}, 32'h0);
        chk("wr_we_pulse2", {31'h0, tr_we[3]}, 32'h0);
        chk("wr_we_hold", {31'h0, tr_we[4]}, 32'h1);
        chk("wr_dqoe_hold", {31'h0, tr_dqoe[4]}, 32'h1);
        chk("wr_be_n_hold", {28'h0, tr_ben[4]}, 32'hC);
        chk("wr_dqoe_done", {31'h0, tr_dqoe[5]}, 32'h0);
        count_lows(lat, ce_l, oe_l, we_l);
        chk("wr_we_lows", we_l, 32'd2);
        chk("wr_oe_lows", oe_l, 32'd0);

        // Write with empty byte mask
        push_exp(1'b1, 1'b0, 32'h0);
        do_req(1'b1, 1'b1, 32'h0000_0300, 32'h1234_5678, 4'h0, 1'b1, "wr_sel0", lat);
        chk("sel0_latency", lat, 32'd2);
        count_lows(lat, ce_l, oe_l, we_l);
        chk("sel0_ce_lows", ce_l, 32'd0);
        chk("sel0_we_lows", we_l, 32'd0);

        // Both ports after reset: data first, stall held until the fetch completes
        apply_reset();
        push_exp(1'b1, 1'b1, 32'hABC0_0080);
        push_exp(1'b0, 1'b1, 32'hABC0_0010);
        fork
            do_req(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 1'b0, "both_data", lat_d);
            do_req(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b0, "both_inst", lat_i);
            begin
                bit seen;
                seen = 1'b0;
                @(posedge clk);
                for (int k = 0; k < 100 && !seen; k++) begin
                    @(negedge clk);
                    if (inst_ready) begin
                        chk("both_stall_end", {31'h0, stall}, 32'h0);
                        seen = 1'b1;
                    end else begin
                        chk("both_stall", {31'h0, stall}, 32'h1);
                    end
                end
            end
        join
        chk("both_data_lat", lat_d, 32'd3);
        chk("both_inst_lat", lat_i, 32'd6);

        // Reset during the write pulse aborts cleanly
        @(posedge clk);
        #1;
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 32'h0000_0020;
        data_wdata = 32'h1111_2222;
        data_sel   = 4'hF;
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("abort_in_pulse", {31'h0, sram_we_n}, 32'h0);
        #1;
        rst_n    = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        chk("abort_we_n", {31'h0, sram_we_n}, 32'h1);
        chk("abort_ce_n", {31'h0, sram_ce_n}, 32'h1);
        chk("abort_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
        chk("abort_ready", {31'h0, data_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(1'b1, 1'b1, 32'hABC0_0008);
        do_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b0, "after_abort", lat);
        chk("after_abort_lat", lat, 32'd3);

        // Fetch held continuously against three back-to-back data reads
        apply_reset();
        alt_addr[0] = 32'h0000_0400;
        alt_addr[1] = 32'h0000_0404;
        alt_addr[2] = 32'h0000_0408;
        push_exp(1'b1, 1'b1, 32'hABC0_0100);
        push_exp(1'b0, 1'b1, 32'hABC0_0040);
        push_exp(1'b1, 1'b1, 32'hABC0_0101);
        push_exp(1'b0, 1'b1, 32'hABC0_0040);
        push_exp(1'b1, 1'b1, 32'hABC0_0102);
        push_exp(1'b0, 1'b1, 32'hABC0_0040);
        fork
            begin
                int n;
                n = 0;
                @(posedge clk);
                #1;
                inst_req  = 1'b1;
                inst_addr = 32'h0000_0100;
                for (int k = 0; k < 200 && n < 3; k++) begin
                    @(negedge clk);
                    if (inst_ready) n++;
                end
                #1;
                inst_req = 1'b0;
                if (n < 3) timeout_fail("alt_inst");
            end
            begin
                int n;
                n = 0;
                @(posedge clk);
                #1;
                data_req  = 1'b1;
                data_we   = 1'b0;
                data_sel  = 4'hF;
                data_addr = alt_addr[0];
                for (int k = 0; k < 200 && n < 3; k++) begin
                    @(negedge clk);
                    if (data_ready) begin
                        n++;
                        #1;
                        if (n < 3) data_addr = alt_addr[n];
                        else data_req = 1'b0;
                    end
                end
                if (n < 3) begin
                    data_req = 1'b0;
                    timeout_fail("alt_data");
                end
            end
        join

        repeat (10) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
